// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
//   addr_width()    : address width for a given entry count (minimum 1)
//   fifo_status_t   : registered occupancy flags, reused by later FIFO variants
package fifo_pkg;

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_1r1w.sv
// Single-port-write / single-port-read storage array.
//   clk, rst_n : clock and synchronous active-low reset (clears all entries)
//   we, waddr, wdata : synchronous write port
//   re, raddr, rdata : read port; combinational when REG_RD=0,
//                      registered with read-enable when REG_RD=1
module fifo_mem_1r1w
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit REG_RD     = 1'b0,
  localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Entries are zeroed on reset so a read of never-written storage is never X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (REG_RD) begin : g_reg_rd
    always_ff @(posedge clk) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end else begin : g_comb_rd
    logic unused_re;
    assign unused_re = re;
    assign rdata     = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, selectable read mode, synchronous flush and sticky errors.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : synchronous clear of pointers/level (memory and errors kept)
//   wen, wdata          : write request / data
//   wfull, walmost_full : registered full / level >= af_thresh
//   ren, rdata, rvalid  : read request / data / data valid
//   rempty, ralmost_empty : registered empty / level <= ae_thresh
//   level               : registered occupancy 0..DEPTH
//   af_thresh, ae_thresh: quasi-static thresholds
//   overflow, underflow : sticky error flags, cleared by clr_err
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b1,
  localparam int ADDR_WIDTH = addr_width(DEPTH),
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [CNT_WIDTH-1:0]  level,
  input  logic [CNT_WIDTH-1:0]  af_thresh,
  input  logic [CNT_WIDTH-1:0]  ae_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  logic [CNT_WIDTH-1:0] wptr, rptr, level_next;
  fifo_status_t         status, status_next;
  logic                 wr_acc, rd_acc, ovf_evt, udf_evt;

  // Acceptance looks only at the registered flags, so a read at full does
  // not open a slot for a same-cycle write (and vice versa at empty).
  always_comb begin
    wr_acc  = wen && !status.full  && !flush;
    rd_acc  = ren && !status.empty && !flush;
    ovf_evt = wen &&  status.full  && !flush;
    udf_evt = ren &&  status.empty && !flush;

    level_next = '0;
    if (!flush) level_next = level + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_acc);

    status_next              = '0;
    status_next.full         = (level_next == CNT_WIDTH'(DEPTH));
    status_next.almost_full  = (level_next >= af_thresh);
    status_next.empty        = (level_next == '0);
    status_next.almost_empty = (level_next <= ae_thresh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      status    <= '{full: 1'b0, almost_full: 1'b0, empty: 1'b1, almost_empty: 1'b1};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + 1'b1;
        if (rd_acc) rptr <= rptr + 1'b1;
      end
      level     <= level_next;
      status    <= status_next;
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow  <= ovf_evt || (overflow  && !clr_err);
      underflow <= udf_evt || (underflow && !clr_err);
    end
  end

  fifo_mem_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .REG_RD     (!FWFT)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  if (FWFT) begin : g_fwft
    assign rvalid = !status.empty;
  end else begin : g_regrd
    logic rvalid_q;
    // rd_acc is already masked by flush, so flush also clears the pulse.
    always_ff @(posedge clk) begin
      if (!rst_n) rvalid_q <= 1'b0;
      else        rvalid_q <= rd_acc;
    end
    assign rvalid = rvalid_q;
  end

  assign wfull         = status.full;
  assign walmost_full  = status.almost_full;
  assign rempty        = status.empty;
  assign ralmost_empty = status.almost_empty;

  // Level is always the modulo-2*DEPTH pointer distance.
  a_level_ptr : assert property (@(posedge clk) disable iff (!rst_n)
    level == CNT_WIDTH'(wptr - rptr));

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: one FWFT instance and one
// registered-read instance. Stimulus pushes expected words; monitors pop.
module tb_sync_fifo_prog;
  localparam int DW = 8;
  localparam int D  = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] af_thresh = CW'(14);
  logic [CW-1:0] ae_thresh = CW'(2);

  always #5 clk = ~clk;

  // FWFT instance
  logic f_flush = 0, f_wen = 0, f_ren = 0, f_clr = 0;
  logic [DW-1:0] f_wdata = '0, f_rdata;
  logic f_wfull, f_waf, f_rvalid, f_rempty, f_rae, f_ovf, f_udf;
  logic [CW-1:0] f_level;

  // Registered-read instance
  logic r_flush = 0, r_wen = 0, r_ren = 0, r_clr = 0;
  logic [DW-1:0] r_wdata = '0, r_rdata;
  logic r_wfull, r_waf, r_rvalid, r_rempty, r_rae, r_ovf, r_udf;
  logic [CW-1:0] r_level;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wen(f_wen), .wdata(f_wdata),
    .wfull(f_wfull), .walmost_full(f_waf), .ren(f_ren), .rdata(f_rdata),
    .rvalid(f_rvalid), .rempty(f_rempty), .ralmost_empty(f_rae), .level(f_level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(f_ovf),
    .underflow(f_udf), .clr_err(f_clr));

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(r_flush), .wen(r_wen), .wdata(r_wdata),
    .wfull(r_wfull), .walmost_full(r_waf), .ren(r_ren), .rdata(r_rdata),
    .rvalid(r_rvalid), .rempty(r_rempty), .ralmost_empty(r_rae), .level(r_level),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(r_ovf),
    .underflow(r_udf), .clr_err(r_clr));

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FWFT monitor: a word is consumed when ren meets rvalid (flush ignores ren).
  always @(negedge clk) begin
    if (rst_n && f_ren && !f_flush && f_rvalid) begin
      if (fq.size() == 0) check("fwft_unexpected_read", 32'(f_rdata), 32'hFFFF_FFFF);
      else check("fwft_rdata", 32'(f_rdata), 32'(fq.pop_front()));
    end
  end

  // Registered-read monitor: a word is presented while rvalid pulses.
  always @(negedge clk) begin
    if (rst_n && r_rvalid) begin
      if (rq.size() == 0) check("reg_unexpected_read", 32'(r_rdata), 32'hFFFF_FFFF);
      else check("reg_rdata", 32'(r_rdata), 32'(rq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_wfull", 32'(f_wfull), 0);
    check("rst_waf", 32'(f_waf), 0);
    check("rst_rempty", 32'(f_rempty), 1);
    check("rst_rae", 32'(f_rae), 1);
    check("rst_level", 32'(f_level), 0);
    check("rst_ovf", 32'(f_ovf), 0);
    check("rst_udf", 32'(f_udf), 0);
    check("rst_rvalid", 32'(f_rvalid), 0);
    check("rst_reg_rvalid", 32'(r_rvalid), 0);
    check("rst_reg_rdata", 32'(r_rdata), 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      f_wen = 1; f_wdata = DW'(i); fq.push_back(DW'(i));
      tick();
      check("fill_level", 32'(f_level), 32'(i + 1));
      check("fill_wfull", 32'(f_wfull), (i == 15) ? 1 : 0);
      check("fill_waf", 32'(f_waf), (i + 1 >= 14) ? 1 : 0);
      check("fill_rae", 32'(f_rae), (i + 1 <= 2) ? 1 : 0);
    end
    // Write at full is dropped
    f_wdata = 8'hAA;
    tick();
    f_wen = 0;
    check("full_ovf", 32'(f_ovf), 1);
    check("full_level", 32'(f_level), 16);
    f_clr = 1; tick(); f_clr = 0;
    check("clr_ovf", 32'(f_ovf), 0);

    // Drain 16, order checked by monitor
    f_ren = 1;
    for (int i = 0; i < 16; i++) tick();
    f_ren = 0;
    check("drain_rempty", 32'(f_rempty), 1);
    check("drain_level", 32'(f_level), 0);
    check("drain_udf", 32'(f_udf), 0);

    // Read at empty with simultaneous write
    f_wen = 1; f_ren = 1; f_wdata = 8'h5A; fq.push_back(8'h5A);
    tick();
    f_wen = 0;
    check("uf_udf", 32'(f_udf), 1);
    check("uf_level", 32'(f_level), 1);
    check("uf_rempty", 32'(f_rempty), 0);
    tick();
    f_ren = 0;
    check("uf_rempty2", 32'(f_rempty), 1);
    check("uf_rae", 32'(f_rae), 1);
    f_clr = 1; tick(); f_clr = 0;
    check("clr_udf", 32'(f_udf), 0);

    // Stream at level 8 across pointer wrap
    for (int i = 0; i < 8; i++) begin
      f_wen = 1; f_wdata = DW'(8'h80 + i); fq.push_back(f_wdata);
      tick();
    end
    check("stream_start_level", 32'(f_level), 8);
    f_ren = 1;
    for (int i = 0; i < 40; i++) begin
      f_wdata = DW'(8'hC0 + i); fq.push_back(f_wdata);
      tick();
      check("stream_level", 32'(f_level), 8);
    end
    f_wen = 0;
    for (int i = 0; i < 8; i++) tick();
    f_ren = 0;
    check("stream_rempty", 32'(f_rempty), 1);
    check("stream_ovf", 32'(f_ovf), 0);
    check("stream_udf", 32'(f_udf), 0);

    // Flush at level 5 with wen/ren
    for (int i = 0; i < 5; i++) begin
      f_wen = 1; f_wdata = DW'(8'h30 + i);
      tick();
    end
    check("pre_flush_level", 32'(f_level), 5);
    f_flush = 1; f_wen = 1; f_ren = 1; f_wdata = 8'hEE;
    tick();
    f_flush = 0; f_wen = 0; f_ren = 0;
    check("flush_level", 32'(f_level), 0);
    check("flush_rempty", 32'(f_rempty), 1);
    check("flush_wfull", 32'(f_wfull), 0);
    check("flush_ovf", 32'(f_ovf), 0);
    check("flush_udf", 32'(f_udf), 0);
    f_wen = 1; f_wdata = 8'h77; fq.push_back(8'h77);
    tick();
    f_wen = 0; f_ren = 1;
    tick();
    f_ren = 0;
    check("post_flush_rempty", 32'(f_rempty), 1);

    // Registered read mode
    r_wen = 1; r_wdata = 8'h11; rq.push_back(8'h11); tick();
    r_wdata = 8'h22; rq.push_back(8'h22); tick();
    r_wen = 0;
    check("reg_rvalid_idle", 32'(r_rvalid), 0);
    r_ren = 1; tick();
    check("reg_rvalid_pulse", 32'(r_rvalid), 1);
    tick();
    r_ren = 0; tick();
    check("reg_rvalid_low", 32'(r_rvalid), 0);
    check("reg_rdata_hold", 32'(r_rdata), 32'h22);
    check("reg_rempty", 32'(r_rempty), 1);
    r_wen = 1; r_wdata = 8'h33; rq.push_back(8'h33); tick();
    r_wen = 0; r_ren = 1; tick();
    r_ren = 0; r_flush = 1; tick();
    r_flush = 0;
    check("reg_flush_rvalid", 32'(r_rvalid), 0);

    tick();
    check("fwft_queue_empty", 32'(fq.size()), 0);
    check("reg_queue_empty", 32'(rq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock FIFO, parametrised successor to our dual-clock pointer FIFO. Used where producer and consumer share one clock and no CDC is needed. Adds an occupancy count, programmable almost-full/almost-empty thresholds, a selectable read mode (first-word-fall-through or registered), synchronous flush and sticky overflow/underflow error flags. Flags are exact with no synchroniser lag.

## Interface
- DATA_WIDTH, 8, word width.
- DEPTH, 16, entries. Must be a power of 2, ≥4.
- FWFT, 1, read mode.
  - 1: head word is presented combinationally whenever not empty.
  - 0: read data is registered, one cycle after the read is accepted.
- Derived constants: ADDR_WIDTH = $clog2(DEPTH), CNT_WIDTH = ADDR_WIDTH+1.

Ports:
- clk  in  1  clock, all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of contents.
- wen  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered; set when level ≥ af_thresh.
- ren  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata is valid.
- rempty  out  1  registered empty flag.
- ralmost_empty  out  1  registered; set when level ≤ ae_thresh.
- level  out  CNT_WIDTH  registered occupancy, 0..DEPTH.
- af_thresh  in  CNT_WIDTH  almost-full threshold, treated as quasi-static.
- ae_thresh  in  CNT_WIDTH  almost-empty threshold, treated as quasi-static.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

## Operation
- Write is accepted when wen && !wfull. The word is stored at wptr[ADDR_WIDTH-1:0] and wptr increments.
- Read is accepted when ren && !rempty. rptr increments.
- Pointers are CNT_WIDTH binary and wrap naturally modulo 2·DEPTH. Address bits are the low ADDR_WIDTH bits.
- level_next = level + wr_acc − rd_acc.
- Flags are computed from level_next and registered:
  - wfull = (level_next == DEPTH).
  - rempty = (level_next == 0).
  - walmost_full = (level_next ≥ af_thresh).
  - ralmost_empty = (level_next ≤ ae_thresh).
- Rejected requests do not change pointers, memory or level:
  - A write while full is dropped and sets overflow.
  - A read while empty is dropped and sets underflow.
- Acceptance uses the registered flags only:
  - Write at full with a simultaneous accepted read: the write is still rejected.
  - Read at empty with a simultaneous write: the read is still rejected.
- Simultaneous accepted read and write leave level unchanged.
- clr_err clears both sticky flags. A new error event in the same cycle wins, so the flag stays 1.
- flush zeroes wptr, rptr and level, and sets flags to their empty state. Same-cycle wen and ren are ignored and raise no error. Memory contents and error flags are untouched.
- FWFT=1:
  - rdata = mem[rptr]; rvalid = !rempty.
  - An accepted read advances to the next word at the following edge.
- FWFT=0:
  - An accepted read loads rdata from mem[rptr] at that edge and pulses rvalid for one cycle.
  - rdata holds its value otherwise.
  - flush clears rvalid.

## Timing
- Reset values: wfull 0, walmost_full 0, rempty 1, ralmost_empty 1, level 0, overflow 0, underflow 0, rvalid 0 (FWFT=0), rdata 0 in FWFT=0 mode. In FWFT=1, rdata is undefined while rempty.
- rst_n has priority over flush, which has priority over wen/ren.
- Write-to-read latency: a write accepted at edge N deasserts rempty after edge N; the word is readable in cycle N+1.
- FWFT=1: data is visible in the same cycle as rvalid.
- FWFT=0: rdata/rvalid appear one edge after the accepted ren.
- Full throughput: one write and one read per cycle sustained at any level 1..DEPTH−1.
- Mid-operation reset: the effect is identical to reset from idle on the next edge. Contents are discarded.
- Memory is initialised to zero to prevent X propagation.

## Structure
- Package fifo_pkg holds:
  - the clog2-derived width helper,
  - a status struct {full, almost_full, empty, almost_empty} reused by later FIFO variants.
- Sub-module fifo_mem_1r1w(DATA_WIDTH, DEPTH, REG_RD):
  - synchronous write port,
  - combinational read when REG_RD=0, registered read with read-enable when REG_RD=1.
- The top holds pointers, level, flags and the error logic.

## Test plan
- Reset, then write 16 words 0x00..0x0F (DEPTH=16): level steps 1..16; wfull rises after the 16th edge; walmost_full rises at level 14 with af_thresh=14.
- At full, wen with 0xAA: the write is dropped and overflow=1. Assert clr_err alone: overflow=0. Read back 16 words: they come out in order 0x00..0x0F (FWFT=1: one word per accepted ren, same cycle).
- Write 0x5A to an empty FIFO with ren also high: underflow=1 and level=1. Next cycle ren: rdata=0x5A, then rempty=1 and ralmost_empty=1 with ae_thresh=2.
- With level=8, drive simultaneous wen and ren for 40 cycles, writing an incrementing pattern: level stays 8, data order is preserved across pointer wrap, and no error flags are set.
- Build with FWFT=0 and write 0x11, 0x22: ren at edge N gives rdata=0x11 with an rvalid pulse after N; the next ren gives 0x22.
- With level=5, assert flush together with wen and ren: level=0, rempty=1, wfull=0, no error flags; the next write of 0x77 reads back as 0x77.
